// File: rtl/traffic_light_multi.sv
// Demand-actuated traffic-light controller for NUM_DIRS conflicting approaches,
// with all-red clearance, resting green, freeze enable and flashing-yellow fault mode.
module traffic_light_multi #(
    parameter int NUM_DIRS      = 2,
    parameter int GREEN_CYCLES  = 20,
    parameter int YELLOW_CYCLES = 7,
    parameter int ALLRED_CYCLES = 3,
    parameter int FLASH_HALF    = 4,
    parameter int CNT_W         = 8,
    localparam int PH_W         = (NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                flash,
    input  logic [NUM_DIRS-1:0] sensor,
    output logic [NUM_DIRS-1:0] red,
    output logic [NUM_DIRS-1:0] yellow,
    output logic [NUM_DIRS-1:0] green,
    output logic [PH_W-1:0]     phase
);

    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);

    state_t            state;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  flash_cnt;
    logic              flash_on;
    logic [PH_W-1:0]   next_dir;
    logic [PH_W-1:0]   cand;
    logic              found;
    logic              other_demand;

    function automatic logic [NUM_DIRS-1:0] onehot(input logic [PH_W-1:0] p);
        return NUM_DIRS'(1) << p;
    endfunction

    // Round-robin search for the next approach with demand, falling back to plain rotation.
    always_comb begin
        next_dir = (int'(phase) == NUM_DIRS - 1) ? '0 : phase + PH_W'(1);
        cand     = '0;
        found    = 1'b0;
        for (int k = 1; k < NUM_DIRS; k++) begin
            cand = PH_W'((int'(phase) + k) % NUM_DIRS);
            if (!found && sensor[cand]) begin
                next_dir = cand;
                found    = 1'b1;
            end
        end
    end

    assign other_demand = |(sensor & ~onehot(phase));

    // Flash takes priority over everything; otherwise the normal sequence advances only when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ALLRED;
            timer     <= '0;
            phase     <= PH_W'(NUM_DIRS - 1);
            red       <= '1;
            yellow    <= '0;
            green     <= '0;
            flash_cnt <= '0;
            flash_on  <= 1'b0;
        end else if (flash) begin
            if (state != ST_FLASH) begin
                state     <= ST_FLASH;
                timer     <= '0;
                flash_cnt <= '0;
                flash_on  <= 1'b1;
                red       <= '0;
                green     <= '0;
                yellow    <= '1;
            end else if (flash_cnt == FLASH_LAST) begin
                flash_cnt <= '0;
                flash_on  <= ~flash_on;
                yellow    <= {NUM_DIRS{~flash_on}};
            end else begin
                flash_cnt <= flash_cnt + CNT_W'(1);
            end
        end else if (state == ST_FLASH) begin
            // Phase is kept so the first green after the fault goes to next_dir.
            state    <= ST_ALLRED;
            timer    <= '0;
            flash_on <= 1'b0;
            red      <= '1;
            yellow   <= '0;
            green    <= '0;
        end else if (enable) begin
            case (state)
                ST_ALLRED: begin
                    if (timer == ALLRED_LAST) begin
                        state <= ST_GREEN;
                        timer <= '0;
                        phase <= next_dir;
                        red   <= ~onehot(next_dir);
                        green <= onehot(next_dir);
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                ST_GREEN: begin
                    if (timer >= GREEN_LAST) begin
                        if (other_demand) begin
                            state  <= ST_YELLOW;
                            timer  <= '0;
                            green  <= '0;
                            yellow <= onehot(phase);
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                ST_YELLOW: begin
                    if (timer == YELLOW_LAST) begin
                        state  <= ST_ALLRED;
                        timer  <= '0;
                        yellow <= '0;
                        red    <= '1;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: state <= ST_ALLRED;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_multi.sv
// Directed bench for traffic_light_multi: a 2-approach and a 4-approach instance share
// clock, reset, enable and flash; expected lamp states are queued and popped after each edge.
module tb_traffic_light_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       flash;
    logic [1:0] sensor2;
    logic [3:0] sensor4;
    logic [1:0] red2, yellow2, green2;
    logic [0:0] phase2;
    logic [3:0] red4, yellow4, green4;
    logic [1:0] phase4;

    always #5 clk = ~clk;

    traffic_light_multi #(.NUM_DIRS(2)) dut2 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .flash  (flash),
        .sensor (sensor2),
        .red    (red2),
        .yellow (yellow2),
        .green  (green2),
        .phase  (phase2)
    );

    traffic_light_multi #(.NUM_DIRS(4)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .flash  (flash),
        .sensor (sensor4),
        .red    (red4),
        .yellow (yellow4),
        .green  (green4),
        .phase  (phase4)
    );

    // lamps packs {red, yellow, green, phase} as 4/4/4/2 bits, narrower instance zero-extended.
    typedef struct {
        string       tag;
        bit          four;
        logic [13:0] lamps;
    } exp_t;

    exp_t        sb[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    bit          inv_on;
    logic [3:0]  prev_y2, prev_y4;

    function automatic bit lamps_safe(input logic [3:0] r, input logic [3:0] y,
                                      input logic [3:0] g, input logic [3:0] py);
        for (int i = 0; i < 4; i++)
            if ((int'(r[i]) + int'(y[i]) + int'(g[i])) != 1) return 1'b0;
        if ($countones(g | y) > 1) return 1'b0;
        if ((g & py) != 4'b0000) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pushExpect(input string tag, input bit four, input logic [13:0] lamps);
        exp_t e;
        e.tag   = tag;
        e.four  = four;
        e.lamps = lamps;
        sb.push_back(e);
    endtask

    task automatic pushReset(input string tag);
        pushExpect(tag, 1'b0, {4'b0011, 4'b0000, 4'b0000, 2'b01});
        pushExpect(tag, 1'b1, {4'b1111, 4'b0000, 4'b0000, 2'b11});
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [13:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.four ? {red4, yellow4, green4, phase4}
                         : {2'b00, red2, 2'b00, yellow2, 2'b00, green2, 1'b0, phase2};
            tests_run++;
            assert (obs === e.lamps) else begin
                tests_failed++;
                $error("[TB] FAIL %s: observed r/y/g/ph=%b required %b", e.tag, obs, e.lamps);
            end
        end
        if (inv_on) begin
            tests_run++;
            assert (lamps_safe({2'b11, red2}, {2'b00, yellow2}, {2'b00, green2}, prev_y2)) else begin
                tests_failed++;
                $error("[TB] FAIL invariant2: observed r=%b y=%b g=%b prev_y=%b required safe lamps",
                       red2, yellow2, green2, prev_y2);
            end
            tests_run++;
            assert (lamps_safe(red4, yellow4, green4, prev_y4)) else begin
                tests_failed++;
                $error("[TB] FAIL invariant4: observed r=%b y=%b g=%b prev_y=%b required safe lamps",
                       red4, yellow4, green4, prev_y4);
            end
        end
        prev_y2 = {2'b00, yellow2};
        prev_y4 = yellow4;
    endtask

    // One edge per iteration; chk4 selects whether the 4-approach expectation is queued too.
    task automatic applyStimulus(input string tag, input int n, input bit chk4,
                                 input logic [1:0] r2, input logic [1:0] y2,
                                 input logic [1:0] g2, input logic ph2,
                                 input logic [3:0] r4, input logic [3:0] y4,
                                 input logic [3:0] g4, input logic [1:0] ph4);
        for (int i = 0; i < n; i++) begin
            pushExpect(tag, 1'b0, {2'b00, r2, 2'b00, y2, 2'b00, g2, 1'b0, ph2});
            if (chk4) pushExpect(tag, 1'b1, {r4, y4, g4, ph4});
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    task automatic fullRotation(input string tag);
        applyStimulus({tag, "_allred0"},  2, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd3);
        applyStimulus({tag, "_green0"},  20, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 4'b1110, 4'b0000, 4'b0001, 2'd0);
        applyStimulus({tag, "_yellow0"},  7, 1'b1, 2'b10, 2'b01, 2'b00, 1'b0, 4'b1110, 4'b0001, 4'b0000, 2'd0);
        applyStimulus({tag, "_allred1"},  3, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0);
        applyStimulus({tag, "_green1"},  20, 1'b1, 2'b01, 2'b00, 2'b10, 1'b1, 4'b1011, 4'b0000, 4'b0100, 2'd2);
        applyStimulus({tag, "_yellow1"},  7, 1'b1, 2'b01, 2'b10, 2'b00, 1'b1, 4'b1011, 4'b0100, 4'b0000, 2'd2);
        applyStimulus({tag, "_allred2"},  3, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd2);
        applyStimulus({tag, "_period"},   1, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 4'b1110, 4'b0000, 4'b0001, 2'd0);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        flash   = 1'b0;
        sensor2 = 2'b11;
        sensor4 = 4'b0101;
        inv_on  = 1'b0;
        prev_y2 = 4'b0000;
        prev_y4 = 4'b0000;

        repeat (2) @(posedge clk);
        #1;
        pushReset("reset_state");
        checkOutput();
        reset  = 1'b0;
        inv_on = 1'b1;

        // Full demand on the 2-way, approaches 0 and 2 only on the 4-way.
        fullRotation("s1");

        // dut2 rests in green 0 with no competing demand.
        sensor2 = 2'b01;
        applyStimulus("s2_rest_a",   19, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 4'b1110, 4'b0000, 4'b0001, 2'd0);
        applyStimulus("s3_yellow0",   7, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 4'b1110, 4'b0001, 4'b0000, 2'd0);
        applyStimulus("s3_allred",    3, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0);
        applyStimulus("s3_green2",    1, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 4'b1011, 4'b0000, 4'b0100, 2'd2);
        applyStimulus("s2_rest_b",   19, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
        sensor2 = 2'b11;
        applyStimulus("s2_yellow",    7, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s2_allred",    3, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s2_green1",    1, 1'b0, 2'b01, 2'b00, 2'b10, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);

        // Freeze after the third yellow cycle.
        applyStimulus("s4_green1",   19, 1'b0, 2'b01, 2'b00, 2'b10, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s4_yellow_a",  3, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        enable = 1'b0;
        applyStimulus("s4_frozen",   10, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        enable = 1'b1;
        applyStimulus("s4_yellow_b",  4, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s4_allred",    3, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s4_green0",    1, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 4'b0, 4'b0, 4'b0, 2'd0);

        // Flash entered during green 1; the flash counter keeps running with enable low.
        applyStimulus("s5_green0",   19, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s5_yellow0",   7, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s5_allred",    3, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s5_green1",    5, 1'b0, 2'b01, 2'b00, 2'b10, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        flash  = 1'b1;
        inv_on = 1'b0;
        applyStimulus("s5_flash_on",  4, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        enable = 1'b0;
        applyStimulus("s5_flash_off", 4, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s5_flash_on2", 4, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        enable = 1'b1;
        flash  = 1'b0;
        inv_on = 1'b1;
        applyStimulus("s5_exit_red",  3, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
        applyStimulus("s5_exit_grn",  5, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 4'b0, 4'b0, 4'b0, 2'd0);

        // Asynchronous reset between edges, then a clean restart.
        #3;
        reset = 1'b1;
        #1;
        pushReset("s6_async_reset");
        checkOutput();
        @(posedge clk);
        #1;
        pushReset("s6_reset_held");
        checkOutput();
        reset = 1'b0;
        fullRotation("s6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
